// File: rtl/if_stage_pc_unit_pkg.sv
// Shared definitions for the IF-stage PC unit: reset/NOP constants, next-PC select
// encoding and small address helpers.
package if_stage_pc_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'd0,
    PCSEL_BR  = 2'd1,
    PCSEL_JR  = 2'd2,
    PCSEL_J   = 2'd3
  } pcSel_e;

  // Fixed priority: a resolved branch beats jr, which beats j/jal.
  function automatic pcSel_e selectNextPc(input logic branchTaken,
                                          input logic jrEn,
                                          input logic jumpEn);
    pcSel_e sel;
    sel = PCSEL_SEQ;
    if (branchTaken)  sel = PCSEL_BR;
    else if (jrEn)    sel = PCSEL_JR;
    else if (jumpEn)  sel = PCSEL_J;
    return sel;
  endfunction

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_unit_if.sv
// Fetch-side bus of the IF stage: instruction memory, ID-stage redirects, IF/ID outputs.
// misalign_err exists only when IF_ALIGN_CHECK_EN is defined.
interface if_stage_pc_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        jr_en;
  logic [31:0] jr_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [3:0]  pc_upper4;
`ifdef IF_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  // The PC unit itself.
  modport slave (
    input  imem_rdata, stall, branch_taken, branch_target,
           jump_en, jump_addr, jr_en, jr_target,
    output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, pc_upper4
`ifdef IF_ALIGN_CHECK_EN
    , output misalign_err
`endif
  );

  // Memory / hazard unit / ID stage surrounding the PC unit.
  modport master (
    output imem_rdata, stall, branch_taken, branch_target,
           jump_en, jump_addr, jr_en, jr_target,
    input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, pc_upper4
`ifdef IF_ALIGN_CHECK_EN
    , input misalign_err
`endif
  );

endinterface

// File: rtl/if_stage_pc_unit_ifid_reg.sv
// Generic pipeline register with hold and flush; flush replaces only the bits selected
// by FLUSH_MASK with FLUSH_VAL and clears the valid flag.
module if_stage_pc_unit_ifid_reg #(
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] FLUSH_MASK = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             dValid,
  output logic [WIDTH-1:0] q,
  output logic             qValid
);

  logic [WIDTH-1:0] dataReg, dataNext, flushData;
  logic             validReg, validNext;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : gFlushBit
      assign flushData[gi] = FLUSH_MASK[gi] ? FLUSH_VAL[gi] : d[gi];
    end
  endgenerate

  // Hold wins over flush: a stalled stage keeps its contents even if a flush is requested.
  always_comb begin
    dataNext  = dataReg;
    validNext = validReg;
    if (!hold) begin
      if (flush) begin
        dataNext  = flushData;
        validNext = 1'b0;
      end else begin
        dataNext  = d;
        validNext = dValid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataReg  <= RESET_VAL;
      validReg <= 1'b0;
    end else begin
      dataReg  <= dataNext;
      validReg <= validNext;
    end
  end

  assign q      = dataReg;
  assign qValid = validReg;

endmodule

// File: rtl/if_stage_pc_unit.sv
// MIPS IF stage: PC register, next-PC selection and IF/ID register (one bubble per redirect).
// IF_ALIGN_CHECK_EN: force redirect targets word-aligned and report misaligned targets.
module if_stage_pc_unit #(
  parameter logic [31:0] RESET_PC  = if_stage_pc_unit_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = if_stage_pc_unit_pkg::NOP_INSTR
) (
  input logic                 clk,
  input logic                 rst_n,
  if_stage_pc_unit_if.slave   bus
);

  import if_stage_pc_unit_pkg::*;

  logic [31:0] pcReg, pcNext;
  logic [31:0] pcPlus4;
  logic [31:0] rawTarget, redirectTarget;
  logic        redirect;
  pcSel_e      pcSel;
  logic [63:0] ifidData;

  assign pcPlus4 = pcReg + PC_STEP;

  always_comb begin
    pcSel     = selectNextPc(bus.branch_taken, bus.jr_en, bus.jump_en);
    rawTarget = pcPlus4;
    case (pcSel)
      PCSEL_BR: rawTarget = bus.branch_target;
      PCSEL_JR: rawTarget = bus.jr_target;
      PCSEL_J:  rawTarget = bus.jump_addr;
      default:  rawTarget = pcPlus4;
    endcase
  end

  assign redirect = (pcSel != PCSEL_SEQ);

`ifdef IF_ALIGN_CHECK_EN
  assign redirectTarget = wordAlign(rawTarget);
`else
  assign redirectTarget = rawTarget;
`endif

  // Stall freezes the PC; redirects seen during a stall are re-asserted by ID afterwards.
  always_comb begin
    pcNext = pcReg;
    if (!bus.stall) begin
      pcNext = redirect ? redirectTarget : pcPlus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcReg <= RESET_PC;
    else        pcReg <= pcNext;
  end

`ifdef IF_ALIGN_CHECK_EN
  logic misalignReg, misalignNext;

  always_comb begin
    misalignNext = misalignReg;
    if (!bus.stall && redirect && (rawTarget[1:0] != 2'b00)) begin
      misalignNext = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalignReg <= 1'b0;
    else        misalignReg <= misalignNext;
  end

  assign bus.misalign_err = misalignReg;
`endif

  // Flush squashes only the instruction word; PC+4 still travels with the bubble.
  if_stage_pc_unit_ifid_reg #(
    .WIDTH      (64),
    .RESET_VAL  ({NOP_INSTR, 32'h0000_0000}),
    .FLUSH_MASK ({32'hFFFF_FFFF, 32'h0000_0000}),
    .FLUSH_VAL  ({NOP_INSTR, 32'h0000_0000})
  ) uIfidReg (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (bus.stall),
    .flush  (redirect),
    .d      ({bus.imem_rdata, pcPlus4}),
    .dValid (1'b1),
    .q      (ifidData),
    .qValid (bus.ifid_valid)
  );

  assign bus.imem_addr     = pcReg;
  assign bus.ifid_instr    = ifidData[63:32];
  assign bus.ifid_pc_plus4 = ifidData[31:0];
  assign bus.pc_upper4     = ifidData[31:28];

endmodule

// File: tb/tb_if_stage_pc_unit.sv
// Directed self-checking bench for if_stage_pc_unit; optional IF_ALIGN_CHECK_EN coverage
// for the misalignment flag.
module tb_if_stage_pc_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  if_stage_pc_unit_if bus();

  if_stage_pc_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: word k holds 0x20080001 + k*0x00010001.
  assign bus.imem_rdata = 32'h2008_0001 + (bus.imem_addr >> 2) * 32'h0001_0001;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    bus.jump_en = 1'b0;      bus.jump_addr = 32'h0;
    bus.jr_en = 1'b0;        bus.jr_target = 32'h0;
  endtask

  task automatic test_reset();
    clearInputs();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=%h", bus.imem_addr, 32'h0); end
    total++; if (bus.ifid_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=%h", bus.ifid_instr, 32'h0); end
    total++; if (bus.ifid_pc_plus4 !== 32'h0) begin bad++; $display("FAIL rst_pp4 got=%h want=%h", bus.ifid_pc_plus4, 32'h0); end
    total++; if (bus.ifid_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.ifid_valid); end
`ifdef IF_ALIGN_CHECK_EN
    total++; if (bus.misalign_err !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b want=0", bus.misalign_err); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: addr=%h ifid_instr=%h valid=%b", bus.imem_addr, bus.ifid_instr, bus.ifid_valid);
  endtask

  task automatic test_sequential();
    logic [31:0] expAddr [4];
    logic [31:0] expInstr [4];
    logic [31:0] expPp4 [4];
    expAddr  = '{32'h4, 32'h8, 32'hC, 32'h10};
    expInstr = '{32'h2008_0001, 32'h2009_0002, 32'h200A_0003, 32'h200B_0004};
    expPp4   = '{32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.imem_addr !== expAddr[i]) begin bad++; $display("FAIL seq_addr[%0d] got=%h want=%h", i, bus.imem_addr, expAddr[i]); end
      total++; if (bus.ifid_instr !== expInstr[i]) begin bad++; $display("FAIL seq_instr[%0d] got=%h want=%h", i, bus.ifid_instr, expInstr[i]); end
      total++; if (bus.ifid_pc_plus4 !== expPp4[i]) begin bad++; $display("FAIL seq_pp4[%0d] got=%h want=%h", i, bus.ifid_pc_plus4, expPp4[i]); end
      total++; if (bus.ifid_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b want=1", i, bus.ifid_valid); end
      $display("seq %0d: addr=%h ifid_instr=%h pp4=%h", i, bus.imem_addr, bus.ifid_instr, bus.ifid_pc_plus4);
    end
  endtask

  task automatic test_jump();
    bus.jump_en = 1'b1; bus.jump_addr = 32'h0040_0020;
    tick();
    total++; if (bus.imem_addr !== 32'h0040_0020) begin bad++; $display("FAIL jump_addr got=%h want=%h", bus.imem_addr, 32'h0040_0020); end
    total++; if (bus.ifid_instr !== 32'h0) begin bad++; $display("FAIL jump_bubble_instr got=%h want=%h", bus.ifid_instr, 32'h0); end
    total++; if (bus.ifid_valid !== 1'b0) begin bad++; $display("FAIL jump_bubble_valid got=%b want=0", bus.ifid_valid); end
    total++; if (bus.ifid_pc_plus4 !== 32'h14) begin bad++; $display("FAIL jump_bubble_pp4 got=%h want=%h", bus.ifid_pc_plus4, 32'h14); end
    total++; if (bus.pc_upper4 !== 4'h0) begin bad++; $display("FAIL jump_upper4 got=%h want=0", bus.pc_upper4); end
    clearInputs();
    tick();
    total++; if (bus.imem_addr !== 32'h0040_0024) begin bad++; $display("FAIL jump_next_addr got=%h want=%h", bus.imem_addr, 32'h0040_0024); end
    total++; if (bus.ifid_valid !== 1'b1) begin bad++; $display("FAIL jump_next_valid got=%b want=1", bus.ifid_valid); end
    $display("jump: addr=%h pp4=%h valid=%b", bus.imem_addr, bus.ifid_pc_plus4, bus.ifid_valid);
  endtask

  task automatic test_stall();
    test_reset();
    tick(); tick();
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (bus.imem_addr !== 32'h8) begin bad++; $display("FAIL stall_addr[%0d] got=%h want=%h", i, bus.imem_addr, 32'h8); end
      total++; if (bus.ifid_instr !== 32'h2009_0002) begin bad++; $display("FAIL stall_instr[%0d] got=%h want=%h", i, bus.ifid_instr, 32'h2009_0002); end
      total++; if (bus.ifid_pc_plus4 !== 32'h8) begin bad++; $display("FAIL stall_pp4[%0d] got=%h want=%h", i, bus.ifid_pc_plus4, 32'h8); end
      total++; if (bus.ifid_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b want=1", i, bus.ifid_valid); end
      $display("stall %0d: addr=%h ifid_instr=%h", i, bus.imem_addr, bus.ifid_instr);
    end
    bus.stall = 1'b0;
    tick();
    total++; if (bus.imem_addr !== 32'h40) begin bad++; $display("FAIL release_addr got=%h want=%h", bus.imem_addr, 32'h40); end
    total++; if (bus.ifid_valid !== 1'b0) begin bad++; $display("FAIL release_valid got=%b want=0", bus.ifid_valid); end
    total++; if (bus.ifid_pc_plus4 !== 32'hC) begin bad++; $display("FAIL release_pp4 got=%h want=%h", bus.ifid_pc_plus4, 32'hC); end
    clearInputs();
    $display("stall release: addr=%h", bus.imem_addr);
  endtask

  task automatic test_priority();
    // PC is 0x40 here.
    bus.branch_taken = 1'b1; bus.branch_target = 32'h100;
    bus.jump_en = 1'b1;      bus.jump_addr = 32'h200;
    tick();
    total++; if (bus.imem_addr !== 32'h100) begin bad++; $display("FAIL prio_br_addr got=%h want=%h", bus.imem_addr, 32'h100); end
    total++; if (bus.ifid_valid !== 1'b0) begin bad++; $display("FAIL prio_br_valid got=%b want=0", bus.ifid_valid); end
    total++; if (bus.ifid_pc_plus4 !== 32'h44) begin bad++; $display("FAIL prio_br_pp4 got=%h want=%h", bus.ifid_pc_plus4, 32'h44); end
    $display("prio br>j: addr=%h", bus.imem_addr);
  endtask

  task automatic test_back_to_back();
    // PC is 0x100; jr beats j, then an immediate branch is still taken.
    bus.branch_taken = 1'b0;
    bus.jr_en = 1'b1; bus.jr_target = 32'h300;
    tick();
    total++; if (bus.imem_addr !== 32'h300) begin bad++; $display("FAIL b2b_jr_addr got=%h want=%h", bus.imem_addr, 32'h300); end
    total++; if (bus.ifid_pc_plus4 !== 32'h104) begin bad++; $display("FAIL b2b_jr_pp4 got=%h want=%h", bus.ifid_pc_plus4, 32'h104); end
    clearInputs();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h500;
    tick();
    total++; if (bus.imem_addr !== 32'h500) begin bad++; $display("FAIL b2b_br_addr got=%h want=%h", bus.imem_addr, 32'h500); end
    total++; if (bus.ifid_pc_plus4 !== 32'h304) begin bad++; $display("FAIL b2b_br_pp4 got=%h want=%h", bus.ifid_pc_plus4, 32'h304); end
    total++; if (bus.ifid_valid !== 1'b0) begin bad++; $display("FAIL b2b_br_valid got=%b want=0", bus.ifid_valid); end
    clearInputs();
    $display("back-to-back: addr=%h", bus.imem_addr);
  endtask

  task automatic test_wrap();
    bus.jump_en = 1'b1; bus.jump_addr = 32'hF000_0000;
    tick();
    clearInputs();
    tick();
    total++; if (bus.imem_addr !== 32'hF000_0004) begin bad++; $display("FAIL hi_addr got=%h want=%h", bus.imem_addr, 32'hF000_0004); end
    total++; if (bus.ifid_instr !== 32'h5C08_0001) begin bad++; $display("FAIL hi_instr got=%h want=%h", bus.ifid_instr, 32'h5C08_0001); end
    total++; if (bus.pc_upper4 !== 4'hF) begin bad++; $display("FAIL hi_upper4 got=%h want=F", bus.pc_upper4); end
    bus.jump_en = 1'b1; bus.jump_addr = 32'hFFFF_FFFC;
    tick();
    total++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top_addr got=%h want=%h", bus.imem_addr, 32'hFFFF_FFFC); end
    clearInputs();
    tick();
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h want=%h", bus.imem_addr, 32'h0); end
    total++; if (bus.ifid_pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pp4 got=%h want=%h", bus.ifid_pc_plus4, 32'h0); end
    total++; if (bus.ifid_instr !== 32'h6007_0000) begin bad++; $display("FAIL wrap_instr got=%h want=%h", bus.ifid_instr, 32'h6007_0000); end
    total++; if (bus.ifid_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b want=1", bus.ifid_valid); end
    $display("wrap: addr=%h pp4=%h", bus.imem_addr, bus.ifid_pc_plus4);
  endtask

  task automatic test_async_reset();
    bus.jr_en = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
    bus.jr_target = 32'h83;
`else
    bus.jr_target = 32'h80;
`endif
    tick();
    clearInputs();
    total++; if (bus.imem_addr !== 32'h80) begin bad++; $display("FAIL jr_addr got=%h want=%h", bus.imem_addr, 32'h80); end
`ifdef IF_ALIGN_CHECK_EN
    total++; if (bus.misalign_err !== 1'b1) begin bad++; $display("FAIL misalign_set got=%b want=1", bus.misalign_err); end
`endif
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL arst_addr got=%h want=%h", bus.imem_addr, 32'h0); end
    total++; if (bus.ifid_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", bus.ifid_valid); end
    total++; if (bus.ifid_pc_plus4 !== 32'h0) begin bad++; $display("FAIL arst_pp4 got=%h want=%h", bus.ifid_pc_plus4, 32'h0); end
    total++; if (bus.ifid_instr !== 32'h0) begin bad++; $display("FAIL arst_instr got=%h want=%h", bus.ifid_instr, 32'h0); end
`ifdef IF_ALIGN_CHECK_EN
    total++; if (bus.misalign_err !== 1'b0) begin bad++; $display("FAIL misalign_clr got=%b want=0", bus.misalign_err); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (bus.imem_addr !== 32'h4) begin bad++; $display("FAIL post_rst_addr got=%h want=%h", bus.imem_addr, 32'h4); end
    total++; if (bus.ifid_instr !== 32'h2008_0001) begin bad++; $display("FAIL post_rst_instr got=%h want=%h", bus.ifid_instr, 32'h2008_0001); end
    $display("async reset: addr=%h ifid_instr=%h", bus.imem_addr, bus.ifid_instr);
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_sequential();
    test_jump();
    test_stall();
    test_priority();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
